// File: rtl/palette_pkg.sv
// palette_pkg: shared state type, reset defaults and LFSR helper for palette_sequencer
package palette_pkg;
  typedef enum logic {HOLD, FADE} state_t;
  localparam logic [23:0] PALETTE_INIT_DEF = 24'hFC3330;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/palette_fade_step.sv
// palette_fade_step: moves one 2-bit colour channel one unit toward its target
//  cur in 2: current channel value
//  tgt in 2: target channel value
//  nxt out 2: cur stepped by 1 toward tgt, saturating at tgt
module palette_fade_step (
  input  logic [1:0] cur,
  input  logic [1:0] tgt,
  output logic [1:0] nxt
);
  always_comb nxt = cur < tgt ? cur + 2'd1 : cur > tgt ? cur - 2'd1 : cur;
endmodule

// File: rtl/palette_sequencer.sv
// palette_sequencer: frame counter plus 4-entry RRGGBB palette that drifts between LFSR-drawn targets
//  clk         in  1   pixel clock
//  reset       in  1   asynchronous active-high reset
//  vsync       in  1   vsync, rising edge marks a frame tick
//  freeze      in  1   stalls palette state and counters (frame_count keeps counting)
//  next_req    in  1   pulse requesting an early palette change
//  palette     out 24  {e3,e2,e1,e0}, registered
//  frame_count out 10  frames since reset, wrapping
//  fading      out 1   high while fading toward a target
//  pal_update  out 1   one-cycle pulse when palette changes
//  Macro PALETTE_SEQ_FADE_EN enables gradual fading; otherwise a drawn target is applied at once.
module palette_sequencer
  import palette_pkg::*;
#(
  parameter int          HOLD_FRAMES  = 120,
  parameter int          FADE_PERIOD  = 4,
  parameter logic [23:0] PALETTE_INIT = PALETTE_INIT_DEF,
  parameter logic [15:0] LFSR_SEED    = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        freeze,
  input  logic        next_req,
  output logic [23:0] palette,
  output logic [9:0]  frame_count,
  output logic        fading,
  output logic        pal_update
);
  state_t      state;
  logic        vsync_q, pending;
  logic [7:0]  hold_cnt, fade_cnt;
  logic [15:0] lfsr, lfsr_nx;
  logic [23:0] target, drawn, stepped;
  logic        tick, draw;
  always_comb begin
    tick    = vsync & ~vsync_q;
    lfsr_nx = lfsr_next(lfsr);
    drawn   = {lfsr_nx[7:0], lfsr_nx};
    // a request arriving on the tick cycle itself is honoured by that tick
    draw    = hold_cnt == 8'(HOLD_FRAMES - 1) | pending | next_req;
  end
  for (genvar i = 0; i < 12; i++) begin : g_step
    palette_fade_step u_step (.cur(palette[2*i +: 2]), .tgt(target[2*i +: 2]), .nxt(stepped[2*i +: 2]));
  end
`ifdef PALETTE_SEQ_FADE_EN
  assign fading = state == FADE;
`else
  assign fading = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q     <= 1'b1;
      state       <= HOLD;
      hold_cnt    <= '0;
      fade_cnt    <= '0;
      pending     <= 1'b0;
      lfsr        <= LFSR_SEED;
      target      <= PALETTE_INIT;
      palette     <= PALETTE_INIT;
      frame_count <= '0;
      pal_update  <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      pal_update <= 1'b0;
      if (next_req) pending <= 1'b1;
      if (tick) frame_count <= frame_count + 10'd1;
      if (tick && !freeze) begin
        if (state == HOLD) begin
          if (draw) begin
            lfsr     <= lfsr_nx;
            target   <= drawn;
            pending  <= 1'b0;
            hold_cnt <= '0;
            fade_cnt <= '0;
`ifdef PALETTE_SEQ_FADE_EN
            state    <= FADE;
`else
            palette    <= drawn;
            pal_update <= drawn != palette;
`endif
          end else hold_cnt <= hold_cnt + 8'd1;
        end else if (fade_cnt == 8'(FADE_PERIOD - 1)) begin
          fade_cnt   <= '0;
          palette    <= stepped;
          pal_update <= stepped != palette;
          if (stepped == target) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end else fade_cnt <= fade_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_palette_sequencer.sv
// tb_palette_sequencer: table-driven and randomized checks of palette_sequencer against a behavioural model
module tb_palette_sequencer;
  localparam int HOLD = 120;
  localparam int FADEP = 4;
`ifdef PALETTE_SEQ_FADE_EN
  localparam bit FADE_EN = 1'b1;
`else
  localparam bit FADE_EN = 1'b0;
`endif
  logic clk = 0, reset, vsync, freeze, next_req;
  logic [23:0] palette;
  logic [9:0] frame_count;
  logic fading, pal_update;
  int vec = 0, bad = 0, upd_seen = 0;

  palette_sequencer dut (.clk(clk), .reset(reset), .vsync(vsync), .freeze(freeze), .next_req(next_req),
    .palette(palette), .frame_count(frame_count), .fading(fading), .pal_update(pal_update));

  always #5 clk = ~clk;

  // behavioural model: channels as small integers, one entry per 2-bit colour channel
  int m_pal[12], m_tgt[12];
  int m_fc, m_hold, m_fcnt;
  bit m_vq, m_fading, m_pend, m_upd;
  int unsigned m_lfsr;

  function automatic logic [23:0] pack_pal();
    logic [23:0] r = 0;
    for (int i = 0; i < 12; i++) r |= 24'(m_pal[i]) << (2 * i);
    return r;
  endfunction

  task automatic load(input logic [23:0] v, output int ch[12]);
    for (int i = 0; i < 12; i++) ch[i] = int'((v >> (2 * i)) & 24'h3);
  endtask

  task automatic mreset();
    load(24'hFC3330, m_pal);
    load(24'hFC3330, m_tgt);
    m_fc = 0; m_hold = 0; m_fcnt = 0;
    m_vq = 1; m_fading = 0; m_pend = 0; m_upd = 0;
    m_lfsr = 32'hACE1;
  endtask

  task automatic model_clock(input bit v, input bit f, input bit n);
    bit tick, same;
    int unsigned fb;
    logic [23:0] old;
    tick = v && !m_vq;
    m_vq = v;
    m_upd = 0;
    if (n) m_pend = 1;
    if (tick) m_fc = (m_fc + 1) % 1024;
    if (tick && !f) begin
      old = pack_pal();
      if (!m_fading) begin
        if (m_hold == HOLD - 1 || m_pend) begin
          fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
          m_lfsr = ((m_lfsr << 1) | fb) & 32'hFFFF;
          load(24'((m_lfsr & 32'hFF) << 16 | m_lfsr), m_tgt);
          m_pend = 0; m_hold = 0; m_fcnt = 0;
          if (FADE_EN) m_fading = 1;
          else begin
            m_pal = m_tgt;
            m_upd = pack_pal() != old;
          end
        end else m_hold++;
      end else begin
        m_fcnt++;
        if (m_fcnt == FADEP) begin
          m_fcnt = 0;
          same = 1;
          for (int i = 0; i < 12; i++) begin
            if (m_pal[i] < m_tgt[i]) m_pal[i]++;
            else if (m_pal[i] > m_tgt[i]) m_pal[i]--;
            if (m_pal[i] != m_tgt[i]) same = 0;
          end
          m_upd = pack_pal() != old;
          if (same) begin m_fading = 0; m_hold = 0; end
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit v, input bit f, input bit n);
    vsync = v; freeze = f; next_req = n;
    model_clock(v, f, n);
    @(posedge clk);
    #1;
    if (pal_update) upd_seen++;
    chk("model", {palette, frame_count, fading, pal_update}, {pack_pal(), 10'(m_fc), m_fading, m_upd});
  endtask

  task automatic tick_(input bit f, input bit n);
    cyc(0, f, 0);
    cyc(1, f, n);
  endtask

  typedef struct {
    int reps; bit frz; bit req;
    logic [23:0] pal; bit fad; int fc; int upd;
  } row_t;
  row_t rows[7];

  task automatic run_row(input int r);
    upd_seen = 0;
    for (int k = 0; k < rows[r].reps; k++) tick_(rows[r].frz, rows[r].req && k == rows[r].reps - 1);
    chk($sformatf("row%0d_pal", r), palette, rows[r].pal);
    chk($sformatf("row%0d_fading", r), fading, rows[r].fad);
    chk($sformatf("row%0d_fc", r), frame_count, rows[r].fc);
    chk($sformatf("row%0d_updates", r), upd_seen, rows[r].upd);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_pal"}, palette, 24'hFC3330);
    chk({name, "_fc"}, frame_count, 0);
    chk({name, "_fading"}, fading, 0);
    chk({name, "_upd"}, pal_update, 0);
  endtask

  initial begin
    rows[0] = '{119, 0, 0, 24'hFC3330, 0, 119, 0};
    rows[1] = '{1, 0, 0, FADE_EN ? 24'hFC3330 : 24'hC359C3, FADE_EN, 120, FADE_EN ? 0 : 1};
    rows[2] = '{12, 0, 0, 24'hC359C3, 0, 132, FADE_EN ? 3 : 0};
    rows[3] = '{10, 0, 0, 24'hC359C3, 0, 142, 0};
    rows[4] = '{1, 0, 1, FADE_EN ? 24'hC359C3 : 24'h87B387, FADE_EN, 143, FADE_EN ? 0 : 1};
    rows[5] = '{50, 1, 0, FADE_EN ? 24'hC359C3 : 24'h87B387, FADE_EN, 193, 0};
    rows[6] = '{8, 0, 0, 24'h87B387, 0, 201, FADE_EN ? 2 : 0};
    reset = 1; vsync = 1; freeze = 0; next_req = 0;
    mreset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 0;
    upd_seen = 0;
    for (int k = 0; k < 100; k++) cyc(1, 0, 0);
    chk("vsync_high_fc", frame_count, 0);
    chk("vsync_high_pal", palette, 24'hFC3330);
    chk("vsync_high_upd", upd_seen, 0);
    for (int r = 0; r < 7; r++) run_row(r);
    if (FADE_EN) begin
      tick_(0, 1);
      chk("req_enter_fade", fading, 1);
      cyc(0, 0, 1);
      for (int k = 0; k < 200 && m_fading; k++) tick_(0, 0);
      chk("fade_exit", fading, 0);
      tick_(0, 0);
      chk("req_in_fade", fading, 1);
    end
    for (int k = 0; k < 1100 && m_fc != 1023; k++) tick_(0, 0);
    chk("fc_at_1023", frame_count, 1023);
    tick_(0, 0);
    chk("fc_wrap", frame_count, 0);
    tick_(0, 1);
    reset = 1;
    #1;
    check_reset_vals("async_reset");
    mreset();
    vsync = 1;
    @(posedge clk);
    #1;
    reset = 0;
    for (int r = 0; r < 3; r++) run_row(r);
    for (int k = 0; k < 2500; k++)
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
